// File: rtl/gf_mul_serial.sv
// Bit-serial GF(2^W) multiplier: MSB-first shift-and-add over W cycles, with an
// optional extra xtime step, behind a valid/ready handshake on both sides.
module gf_mul_serial #(
  parameter int         W    = 8,
  parameter logic [W:0] POLY = 9'h11B
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         scl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] Q
);

  localparam int            IW   = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0]  R    = POLY[W-1:0];
  localparam logic [IW-1:0] LAST = IW'(W - 1);

  typedef enum logic [1:0] {IDLE, BUSY, SCALE, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  acc, a_q, b_q;
  logic [IW-1:0] idx;
  logic          scl_q;
  logic          accept;

  // Multiply by x modulo the field polynomial.
  function automatic logic [W-1:0] xtime(input logic [W-1:0] v);
    return {v[W-2:0], 1'b0} ^ (v[W-1] ? R : '0);
  endfunction

  assign accept = in_valid & in_ready;
  assign Q      = acc;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (idx == '0) state_nxt = scl_q ? SCALE : DONE;
      SCALE:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = accept ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Accept is only possible in IDLE/DONE, so it never collides with a BUSY or SCALE step.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      scl_q <= 1'b0;
    end else if (accept) begin
      acc   <= '0;
      idx   <= LAST;
      a_q   <= A;
      b_q   <= B;
      scl_q <= scl;
    end else begin
      case (state)
        BUSY: begin
          acc <= xtime(acc) ^ (b_q[idx] ? a_q : '0);
          idx <= idx - 1'b1;
        end
        SCALE:   acc <= xtime(acc);
        default: ;
      endcase
    end
  end

endmodule

// File: doc/gf_mul_serial.md
GF_MUL_SERIAL -- requirements
Module: gf_mul_serial

Interface
REQ-001 Parameter W, default 8: field width in bits; legal range 2..16.
REQ-002 Parameter POLY, default 9'h11B: field polynomial of W+1 bits; bit W SHALL be 1; low W bits are the reduction constant R.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  block can accept an operand pair this cycle.
REQ-007 A  input  W  multiplicand, polynomial basis, bit 0 = x^0.
REQ-008 B  input  W  multiplier, polynomial basis.
REQ-009 scl  input  1  mode: 1 = scale product by x after multiply.
REQ-010 out_valid  output  1  Q holds a finished result.
REQ-011 out_ready  input  1  consumer accepts Q this cycle.
REQ-012 Q  output  W  result A*B mod POLY, times x when scl was 1.

Function
REQ-013 The block SHALL define xtime(v) = (v<<1 truncated to W bits) XOR (v[W-1] ? R : 0).
REQ-014 The block SHALL use states IDLE, BUSY, SCALE, DONE.
REQ-015 Accept occurs on any cycle with in_valid=1 and in_ready=1: latch A, B, scl; acc=0; bit index i=W-1; next state BUSY.
REQ-016 in_ready SHALL be 1 in IDLE, and in DONE when out_ready=1; 0 otherwise.
REQ-017 Each BUSY cycle SHALL perform acc = xtime(acc) XOR (B_latched[i] ? A_latched : 0), then decrement i.
REQ-018 After the BUSY step with i=0, next state SHALL be SCALE if latched scl=1, else DONE.
REQ-019 SCALE SHALL last exactly one cycle: acc = xtime(acc), then DONE.
REQ-020 Latency SHALL be W cycles from the accept edge to out_valid=1 with scl=0, and W+1 with scl=1.
REQ-021 In DONE, out_valid=1 and Q=acc, both held stable until out_ready=1.
REQ-022 DONE with out_ready=1 and no accept SHALL go to IDLE; with a simultaneous accept it SHALL go directly to BUSY (back-to-back, no bubble).
REQ-023 out_valid SHALL be 0 in IDLE, BUSY and SCALE; Q is don't-care unless out_valid=1 but SHALL not be X after reset.
REQ-024 Inputs A, B, scl SHALL be ignored outside an accept cycle; changing them mid-operation SHALL not affect the result.
REQ-025 in_valid and out_ready SHALL be ignored in BUSY and SCALE.
REQ-026 Operand 0 on either side SHALL yield Q=0 (or 0 after scaling) with the normal latency; there is no early termination.

Reset
REQ-027 rst=1 at a clock edge SHALL force state IDLE, acc=0, i=0, latched operands=0: in_ready=1, out_valid=0, Q=0 from the following cycle.
REQ-028 rst asserted in BUSY, SCALE or DONE SHALL abort the operation with no output; the pending result is discarded.
REQ-029 rst SHALL take priority over a simultaneous accept or out_ready.

Verification
REQ-030 W=8, POLY=9'h11B: A=0x57, B=0x83, scl=0, out_ready=1 -> out_valid 8 cycles after accept, Q=0xC1.
REQ-031 Same operands with scl=1 -> out_valid after 9 cycles, Q=0x99; A=0x57, B=0x13, scl=0 -> Q=0xFE.
REQ-032 Back-to-back: new pair offered while DONE and out_ready=1 -> accepted that cycle, no idle cycle, both results correct in order.
REQ-033 Backpressure: out_ready=0 for 5 cycles in DONE -> Q and out_valid stable, in_ready=0, in_valid ignored; then accept proceeds.
REQ-034 W=2, POLY=3'b111: 2*2 -> Q=3; 3*3 -> Q=2; latency 2 cycles.
REQ-035 rst pulsed in mid-BUSY -> next cycle in_ready=1, out_valid=0, Q=0; the following op (0x00*0xFF) -> Q=0x00.
